// File: rtl/seq_comp_32.sv
// Sequential magnitude comparator: walks the operands two bits per cycle, MSB pair first,
// and reports equal / not-equal / less-than / greater-than once the last pair is consumed.
module seq_comp_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic             busy,
    output logic             ready,
    output logic             isEqual,
    output logic             isNotEqual,
    output logic             isLessThan,
    output logic             isGreaterThan
);

    localparam int CW = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]    r_cnt;
    logic             r_eq;
    logic             r_gt;

    logic             w_capture;
    logic             w_step;
    logic             w_last;
    logic [WIDTH-1:0] w_a_shift;
    logic [WIDTH-1:0] w_b_shift;
    logic [1:0]       w_a_pair;
    logic [1:0]       w_b_pair;
    logic             w_eq_next;
    logic             w_gt_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_step       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_capture    = 1'b1;
                    w_next_state = RUN;
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (r_cnt == '0) begin
                    w_last       = 1'b1;
                    w_next_state = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    w_capture    = 1'b1;
                    w_next_state = RUN;
                end else begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // The counter doubles as the pair index, so the current pair sits at bit 2*r_cnt.
    assign w_a_shift = r_a >> {r_cnt, 1'b0};
    assign w_b_shift = r_b >> {r_cnt, 1'b0};
    assign w_a_pair  = w_a_shift[1:0];
    assign w_b_pair  = w_b_shift[1:0];
    assign w_eq_next = r_eq & (w_a_pair == w_b_pair);
    assign w_gt_next = r_gt | (r_eq & (w_a_pair > w_b_pair));

    assign busy  = (r_state == RUN);
    assign ready = (r_state == DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_a           <= '0;
            r_b           <= '0;
            r_cnt         <= '0;
            r_eq          <= 1'b1;
            r_gt          <= 1'b0;
            isEqual       <= 1'b0;
            isNotEqual    <= 1'b0;
            isLessThan    <= 1'b0;
            isGreaterThan <= 1'b0;
        end else begin
            if (w_capture) begin
                // Flipping the sign bit maps two's-complement order onto unsigned order.
                r_a   <= {data_operandA[WIDTH-1] ^ is_signed, data_operandA[WIDTH-2:0]};
                r_b   <= {data_operandB[WIDTH-1] ^ is_signed, data_operandB[WIDTH-2:0]};
                r_cnt <= CW'(WIDTH / 2 - 1);
                r_eq  <= 1'b1;
                r_gt  <= 1'b0;
            end else if (w_step) begin
                r_eq <= w_eq_next;
                r_gt <= w_gt_next;
                if (!w_last) begin
                    r_cnt <= r_cnt - CW'(1);
                end
            end
            if (w_last) begin
                isEqual       <= w_eq_next;
                isNotEqual    <= ~w_eq_next;
                isGreaterThan <= w_gt_next;
                isLessThan    <= ~w_eq_next & ~w_gt_next;
            end
        end
    end

endmodule
